// File: rtl/mux_gate_scheduler.sv
// Time-shares one external 2:1 mux cell between two round-robin requesters to evaluate a
// bitwise 2-input function, one bit per cycle, LSB first. Optional check: MUX_GATE_SCHED_SELFCHECK_EN.
module mux_gate_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             mux_i0,
  output logic             mux_i1,
  output logic             mux_sel,
  input  logic             mux_y,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             last_grant;
  logic             id_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] resp_data_reg;
  logic             resp_id_reg;
  logic             grant_valid;
  logic             grant_id;
  logic             bit_a;
  logic             bit_b;

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid & grant_id;

  assign bit_a = a_reg[cnt];
  assign bit_b = b_reg[cnt];

  // a selects between the two mux data inputs, so each function is its pair of cofactors in a.
  always_comb begin
    mux_i0  = 1'b0;
    mux_i1  = 1'b0;
    mux_sel = 1'b0;
    if (state == RUN) begin
      mux_sel = bit_a;
      case (op_reg)
        3'b000: begin mux_i0 = 1'b1;   mux_i1 = ~bit_b; end
        3'b001: begin mux_i0 = ~bit_b; mux_i1 = 1'b0;   end
        3'b010: begin mux_i0 = 1'b0;   mux_i1 = bit_b;  end
        3'b011: begin mux_i0 = bit_b;  mux_i1 = 1'b1;   end
        3'b100: begin mux_i0 = bit_b;  mux_i1 = ~bit_b; end
        3'b101: begin mux_i0 = ~bit_b; mux_i1 = bit_b;  end
        3'b110: begin mux_i0 = 1'b1;   mux_i1 = 1'b0;   end
        default: begin mux_i0 = 1'b0;  mux_i1 = 1'b1;   end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_res
      assign res_next[gi] = (state == RUN && cnt == CW'(gi)) ? mux_y : res[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      id_reg        <= 1'b0;
      op_reg        <= 3'b000;
      a_reg         <= '0;
      b_reg         <= '0;
      res           <= '0;
      resp_data_reg <= '0;
      resp_id_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_reg     <= grant_id ? req1_op : req0_op;
            a_reg      <= grant_id ? req1_a : req0_a;
            b_reg      <= grant_id ? req1_b : req0_b;
            id_reg     <= grant_id;
            last_grant <= grant_id;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          res <= res_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Response registers hold through later jobs until the next DONE.
            resp_data_reg <= res_next;
            resp_id_reg   <= id_reg;
            state         <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign busy       = (state == RUN) || (state == DONE);

`ifdef MUX_GATE_SCHED_SELFCHECK_EN
  logic [WIDTH-1:0] model;
  logic             err_reg;

  always_comb begin
    model = '0;
    case (op_reg)
      3'b000: model = ~(a_reg & b_reg);
      3'b001: model = ~(a_reg | b_reg);
      3'b010: model = a_reg & b_reg;
      3'b011: model = a_reg | b_reg;
      3'b100: model = a_reg ^ b_reg;
      3'b101: model = ~(a_reg ^ b_reg);
      3'b110: model = ~a_reg;
      default: model = a_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state == DONE && model != res) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Randomized and directed bench for mux_gate_scheduler; models the shared mux cell and
// predicts grants and results from the function definitions.
module tb_mux_gate_scheduler;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   v;
  logic [2:0]   op [2];
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic         r0, r1;
  logic         mux_i0, mux_i1, mux_sel, mux_y;
  logic         resp_valid, resp_id, busy, err;
  logic [W-1:0] resp_data;
  logic         force_zero;

  int           n_tests;
  int           n_fail;
  logic         model_last;
  logic         last_id;
  logic [W-1:0] last_data;

  always #5 clk = ~clk;

  // The shared external mux cell, with an optional stuck-at-0 output.
  assign mux_y = force_zero ? 1'b0 : (mux_sel ? mux_i1 : mux_i0);

  mux_gate_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_ready (r0),
    .req0_op    (op[0]),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req1_valid (v[1]),
    .req1_ready (r1),
    .req1_op    (op[1]),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .mux_i0     (mux_i0),
    .mux_i1     (mux_i1),
    .mux_sel    (mux_sel),
    .mux_y      (mux_y),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    case (f)
      3'd0: return ~(x & y);
      3'd1: return ~(x | y);
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Enter just after a clock edge with the DUT idle; serve at most one job to completion.
  task automatic run_transaction(input bit keep);
    int           gid;
    logic [1:0]   exp_ready;
    logic [2:0]   jop;
    logic [W-1:0] ja, jb, exp;
    @(negedge clk);
    check("idle_flags", {26'd0, busy, resp_valid, mux_i0, mux_i1, mux_sel, err}, 32'd0);
    check("resp_hold", {27'd0, resp_id, resp_data}, {27'd0, last_id, last_data});
    gid = -1;
    if (v[0] && v[1]) gid = model_last ? 0 : 1;
    else if (v[0]) gid = 0;
    else if (v[1]) gid = 1;
    exp_ready = (gid < 0) ? 2'b00 : ((gid == 0) ? 2'b01 : 2'b10);
    check("ready", {30'd0, r1, r0}, {30'd0, exp_ready});
    if (gid < 0) begin
      @(posedge clk); #1;
      return;
    end
    jop = op[gid];
    ja  = a[gid];
    jb  = b[gid];
    exp = ref_fn(jop, ja, jb);
    @(posedge clk); #1;
    model_last = (gid == 1);
    if (keep) begin
      a[gid] = W'($urandom);
      b[gid] = W'($urandom);
    end else begin
      v[gid]  = 1'b0;
      op[gid] = 3'($urandom);
      a[gid]  = W'($urandom);
      b[gid]  = W'($urandom);
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("run_flags", {28'd0, busy, resp_valid, r1, r0}, 32'h8);
      check("mux_sel", {31'd0, mux_sel}, {31'd0, ja[k]});
      check("mux_bit", {31'd0, mux_y}, {31'd0, exp[k]});
    end
    @(negedge clk);
    check("done_flags", {25'd0, busy, resp_valid, r1, r0, mux_i0, mux_i1, mux_sel}, 32'h60);
    check("resp_id", {31'd0, resp_id}, 32'(gid));
    check("resp_data", {28'd0, resp_data}, {28'd0, exp});
    last_id   = (gid == 1);
    last_data = exp;
    $display("[TB] job id=%0d op=%0d a=%b b=%b resp=%b", gid, jop, ja, jb, resp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    v          = 2'b00;
    force_zero = 1'b0;
    model_last = 1'b1;
    last_id    = 1'b0;
    last_data  = '0;
    for (int i = 0; i < 2; i++) begin
      op[i] = 3'd0;
      a[i]  = '0;
      b[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {22'd0, r0, r1, busy, resp_valid, resp_id, mux_i0, mux_i1, mux_sel, err, 1'b0},
          32'd0);
    check("reset_data", {28'd0, resp_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both requesters valid from reset with OR: strict alternation starting with req0.
    v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      op[i] = 3'b011;
      a[i]  = W'($urandom);
      b[i]  = W'($urandom);
    end
    for (int j = 0; j < 4; j++) run_transaction(1'b1);
    v = 2'b00;

    // Directed NAND on req0 and XOR on req1.
    v[0] = 1'b1; op[0] = 3'b000; a[0] = 4'b1100; b[0] = 4'b1010;
    run_transaction(1'b0);
    v[1] = 1'b1; op[1] = 3'b100; a[1] = 4'b1100; b[1] = 4'b1010;
    run_transaction(1'b0);

    // Every function on the reference operands, alternating requesters.
    for (int f = 0; f < 8; f++) begin
      v[f % 2]  = 1'b1;
      op[f % 2] = 3'(f);
      a[f % 2]  = 4'b1100;
      b[f % 2]  = 4'b1010;
      run_transaction(1'b0);
    end

    // Random valid patterns and operands.
    for (int t = 0; t < 30; t++) begin
      v = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        op[i] = 3'($urandom);
        a[i]  = W'($urandom);
        b[i]  = W'($urandom);
      end
      run_transaction(1'b0);
    end
    v = 2'b00;

    // Reset in the second RUN cycle drops the job without a response.
    v[0] = 1'b1; op[0] = 3'b100; a[0] = 4'b1110; b[0] = 4'b0000;
    @(negedge clk);
    check("mid_ready", {30'd0, r1, r0}, 32'h1);
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    check("mid_run", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {25'd0, busy, resp_valid, mux_i0, mux_i1, mux_sel, resp_id, err}, 32'd0);
    check("mid_rst_data", {28'd0, resp_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    last_id    = 1'b0;
    last_data  = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("no_resp", {30'd0, resp_valid, busy}, 32'd0);
    end
    @(posedge clk); #1;
    v[1] = 1'b1; op[1] = 3'b101; a[1] = 4'b0110; b[1] = 4'b0011;
    run_transaction(1'b0);

`ifdef MUX_GATE_SCHED_SELFCHECK_EN
    // Stuck-at-0 mux output must raise the sticky error after the DONE of an OR job.
    force_zero = 1'b1;
    v[0] = 1'b1; op[0] = 3'b011; a[0] = 4'b1100; b[0] = 4'b1010;
    @(negedge clk);
    check("sc_ready", {30'd0, r1, r0}, 32'h1);
    @(posedge clk); #1;
    v[0] = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("sc_err_pre", {31'd0, err}, 32'd0);
    end
    @(negedge clk);
    check("sc_done", {30'd0, resp_valid, err}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sc_err_sticky", {31'd0, err}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("sc_err_clear", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    force_zero = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
